// File: rtl/logic_op_fifo.sv
// Bitwise-op result FIFO: each accepted put computes XOR/AND/OR of two operands and queues the result for a get handshake.
// Optional accumulator op (put_op=11) is built when LOGIC_OP_FIFO_ACC_EN is defined; otherwise put_op=11 acts as XOR.
module logic_op_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [WIDTH-1:0]           put_a,
  input  logic [WIDTH-1:0]           put_b,
  input  logic [1:0]                 put_op,
  input  logic                       EN_put,
  output logic                       RDY_put,
  input  logic                       EN_get,
  output logic [WIDTH-1:0]           get,
  output logic                       RDY_get,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  typedef enum logic [1:0] {
    OP_XOR = 2'b00,
    OP_AND = 2'b01,
    OP_OR  = 2'b10,
    OP_ACC = 2'b11
  } op_e;

  op_e              op;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] result;
  logic             full;
  logic             empty;
  logic             put_fire;
  logic             get_fire;

  assign op = op_e'(put_op);

  // Pointers carry one extra wrap bit so full and empty are distinguishable without a separate counter.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign put_fire = EN_put && !full;
  assign get_fire = EN_get && !empty;

  assign RDY_put = !full;
  assign RDY_get = !empty;
  assign count   = CW'(wr_ptr - rd_ptr);
  assign get     = empty ? '0 : mem[rd_ptr[AW-1:0]];

`ifdef LOGIC_OP_FIFO_ACC_EN
  logic [WIDTH-1:0] acc;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc <= '0;
    end else if (put_fire && op == OP_ACC) begin
      acc <= result;
    end
  end
`endif

  // NOTE: assign a default before the case so every path drives result and no latch is inferred.
  always_comb begin
    result = put_a ^ put_b;
    case (op)
      OP_XOR: result = put_a ^ put_b;
      OP_AND: result = put_a & put_b;
      OP_OR:  result = put_a | put_b;
`ifdef LOGIC_OP_FIFO_ACC_EN
      OP_ACC: result = acc ^ put_a ^ put_b;
`else
      OP_ACC: result = put_a ^ put_b;
`endif
      default: result = put_a ^ put_b;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (put_fire) wr_ptr <= wr_ptr + PTR_ONE;
      if (get_fire) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is reset explicitly so a cleared FIFO never exposes old results, at the cost of losing RAM inference.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (put_fire) begin
      mem[wr_ptr[AW-1:0]] <= result;
    end
  end

endmodule
